// File: rtl/interrupter_mc.sv
// Multi-channel DRSSTC interrupter: OR-combined burst timers gating a feedback-aligned H-bridge drive.
// Optional burst-length cap enabled by defining INTERRUPTER_MC_MAX_ON_EN.
module interrupter_mc #(
    parameter int CH_NUM       = 2,
    parameter int PAR_W        = 8,
    parameter int ADDR_W       = 4,
    parameter int ADDR_BASE    = 4,
    parameter int PERIOD_BASE  = 524288,
    parameter int PERIOD_STEP  = 16384,
    parameter int PW_STEP      = 512,
    parameter int SKIP_CNT_MAX = 3,
    parameter int MAX_ON_CYC   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gen,
    input  logic              ocd,
    input  logic [PAR_W-1:0]  data,
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic              out_p,
    output logic              out_n,
    output logic              win,
    output logic              ocd_act
);
    localparam int MAX_P  = PERIOD_BASE + ((1 << PAR_W) - 1) * PERIOD_STEP;
    localparam int CNT_W  = $clog2(MAX_P);
    localparam int THR_W  = $clog2(((1 << PAR_W) - 1) * PW_STEP + 1);
    localparam int CMP_W  = (CNT_W > THR_W) ? CNT_W : THR_W;
    localparam int SKIP_W = $clog2(SKIP_CNT_MAX + 1);

    if (CH_NUM < 1 || CH_NUM > PAR_W || MAX_ON_CYC < 1) begin : g_cfg_check
        $error("interrupter_mc: unsupported parameter set");
    end

`ifdef INTERRUPTER_MC_MAX_ON_EN
    localparam int ON_W = $clog2(MAX_ON_CYC + 1);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_SKIP = 2'd2, ST_HOLD = 2'd3} state_t;
    logic [ON_W-1:0] on_cnt_r, on_nxt_s;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_SKIP = 2'd2} state_t;
`endif

    logic [PAR_W-1:0]  freq_r [CH_NUM];
    logic [PAR_W-1:0]  pw_r   [CH_NUM];
    logic [CH_NUM-1:0] ch_en_r;
    logic [CNT_W-1:0]  cnt_r     [CH_NUM];
    logic [CNT_W-1:0]  cnt_nxt_s [CH_NUM];
    logic [CH_NUM-1:0] window_s;
    logic              win_r, gen_r, ocd_meta_r, ocd_sync_r;
    logic              rise_s, gen_edge_s;
    state_t            state_r, state_nxt_s;
    logic              ff_r, ff_nxt_s;
    logic [SKIP_W-1:0] skip_cnt_r, skip_nxt_s;
    logic              out_p_r, out_n_r, ocd_act_r;

    // Register file writes from the shared bus; unmatched addresses are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH_NUM; k++) begin
                freq_r[k] <= '0;
                pw_r[k]   <= '0;
            end
            ch_en_r <= '0;
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                if (en && (addr == ADDR_W'(ADDR_BASE + 2 * k)))     freq_r[k] <= data;
                if (en && (addr == ADDR_W'(ADDR_BASE + 2 * k + 1))) pw_r[k]   <= data;
            end
            if (en && (addr == ADDR_W'(ADDR_BASE + 2 * CH_NUM))) ch_en_r <= data[CH_NUM-1:0];
        end
    end

    // Channel timers: period sampled only at reload so freq writes land on the next period
    always_comb begin
        window_s = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (!ch_en_r[k]) begin
                cnt_nxt_s[k] = '0;
            end else if (cnt_r[k] == '0) begin
                cnt_nxt_s[k] = CNT_W'(PERIOD_BASE - 1) + CNT_W'(freq_r[k]) * CNT_W'(PERIOD_STEP);
            end else begin
                cnt_nxt_s[k] = cnt_r[k] - CNT_W'(1);
            end
            window_s[k] = ch_en_r[k] && (CMP_W'(cnt_r[k]) < CMP_W'(pw_r[k]) * CMP_W'(PW_STEP));
        end
    end

    // Counter state and combined window register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < CH_NUM; k++) cnt_r[k] <= '0;
            win_r <= 1'b0;
        end else begin
            for (int k = 0; k < CH_NUM; k++) cnt_r[k] <= cnt_nxt_s[k];
            win_r <= |window_s;
        end
    end

    // Feedback edge history and over-current synchroniser
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_r      <= 1'b0;
            ocd_meta_r <= 1'b0;
            ocd_sync_r <= 1'b0;
        end else begin
            gen_r      <= gen;
            ocd_meta_r <= ocd;
            ocd_sync_r <= ocd_meta_r;
        end
    end

    assign rise_s     = gen & ~gen_r;
    assign gen_edge_s = gen ^ gen_r;

    // Gate FSM next-state: bursts open and close only on gen rises, ocd wins over a rise
    always_comb begin
        state_nxt_s = state_r;
        ff_nxt_s    = ff_r;
        skip_nxt_s  = skip_cnt_r;
`ifdef INTERRUPTER_MC_MAX_ON_EN
        on_nxt_s    = on_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (ocd_sync_r) begin
                    state_nxt_s = ST_SKIP;
                end else if (rise_s && win_r) begin
                    ff_nxt_s    = 1'b1;
                    state_nxt_s = ST_RUN;
`ifdef INTERRUPTER_MC_MAX_ON_EN
                    on_nxt_s    = '0;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ocd_sync_r) begin
                    state_nxt_s = ST_SKIP;
                end else if (rise_s && !win_r) begin
                    ff_nxt_s    = 1'b0;
                    state_nxt_s = ST_IDLE;
`ifdef INTERRUPTER_MC_MAX_ON_EN
                end else if (rise_s && (on_cnt_r == ON_W'(MAX_ON_CYC - 1))) begin
                    ff_nxt_s    = 1'b0;
                    state_nxt_s = ST_HOLD;
                end else if (rise_s) begin
                    on_nxt_s    = on_cnt_r + ON_W'(1);
`endif
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
`ifdef INTERRUPTER_MC_MAX_ON_EN
            ST_HOLD: begin
                if (ocd_sync_r) begin
                    state_nxt_s = ST_SKIP;
                end else if (!win_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
`endif
            ST_SKIP: begin
                if (skip_cnt_r == '0) begin
                    state_nxt_s = ST_IDLE;
                    skip_nxt_s  = SKIP_W'(SKIP_CNT_MAX);
                    ff_nxt_s    = 1'b0;
                end else begin
                    if (gen_edge_s) ff_nxt_s = 1'b0;
                    else            ff_nxt_s = ff_r;
                    if (rise_s) skip_nxt_s = skip_cnt_r - SKIP_W'(1);
                    else        skip_nxt_s = skip_cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ff_nxt_s    = 1'b0;
            end
        endcase
    end

    // FSM state and registered bridge outputs (equivalent to ff gated by gen delayed one clk)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ff_r       <= 1'b0;
            skip_cnt_r <= SKIP_W'(SKIP_CNT_MAX);
            out_p_r    <= 1'b0;
            out_n_r    <= 1'b0;
            ocd_act_r  <= 1'b0;
`ifdef INTERRUPTER_MC_MAX_ON_EN
            on_cnt_r   <= '0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            ff_r       <= ff_nxt_s;
            skip_cnt_r <= skip_nxt_s;
            out_p_r    <= ff_nxt_s & gen;
            out_n_r    <= ff_nxt_s & ~gen;
            ocd_act_r  <= (state_nxt_s == ST_SKIP);
`ifdef INTERRUPTER_MC_MAX_ON_EN
            on_cnt_r   <= on_nxt_s;
`endif
        end
    end

    assign out_p   = out_p_r;
    assign out_n   = out_n_r;
    assign win     = win_r;
    assign ocd_act = ocd_act_r;
endmodule

// File: doc/interrupter_mc.md
Name: interrupter_mc

Overview:
- Multi-channel successor to the single-channel DRSSTC interrupter.
- CH_NUM independent interrupter timers are OR-combined into one burst window. Each timer has its own frequency and pulse-width registers, written over the shared data/addr/en bus.
- A gate FSM aligns the bridge drive to the resonant feedback `gen`. Burst start and end fall on `gen` rising edges, so only whole cycles are driven.
- Over-current (`ocd`) forces a skip of SKIP_CNT_MAX feedback cycles. `out_p`/`out_n` drive the H-bridge halves.

Parameters:
- CH_NUM, 2, number of interrupter channels (1..8)
- PAR_W, 8, width of freq/pw registers and data bus
- ADDR_W, 4, address bus width
- ADDR_BASE, 4, address of ch0 freq register
- PERIOD_BASE, 524288, minimum period in clk cycles
- PERIOD_STEP, 16384, clk cycles added per freq LSB
- PW_STEP, 512, clk cycles of window per pw LSB
- SKIP_CNT_MAX, 3, gen rising edges skipped after OCD
- MAX_ON_CYC, 64, gen cycles per burst cap (optional feature only)

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- gen, in, 1, resonant feedback; already synchronous to clk
- ocd, in, 1, asynchronous over-current flag; 2-FF synchronised internally
- data, in, PAR_W, register write data
- addr, in, ADDR_W, register address
- en, in, 1, write strobe, one cycle
- out_p, out, 1, positive half drive
- out_n, out, 1, negative half drive
- win, out, 1, combined registered window (debug)
- ocd_act, out, 1, high while FSM is in SKIP

Behaviour:
- Reset (async, rst_n=0) sets:
  - all freq/pw registers and the ch_en mask to 0
  - all counters to 0
  - FSM to IDLE, skip_cnt to SKIP_CNT_MAX, ff to 0
  - out_p, out_n, win, ocd_act to 0
  - sync and edge-detect history to 0
- Register map:
  - ADDR_BASE+2k: freq[k]
  - ADDR_BASE+2k+1: pw[k]
  - ADDR_BASE+2*CH_NUM: ch_en mask, low CH_NUM bits used
  - Written when en=1 and addr matches; other addresses are ignored.
- Channel timer k:
  - Period P = PERIOD_BASE + freq[k]*PERIOD_STEP. cnt counts down P-1..0, then reloads P-1.
  - Width is clog2 of the max P. Arithmetic must not truncate at freq=2^PAR_W-1.
  - freq write takes effect at the next reload. pw write takes effect immediately.
  - Window_k = ch_en[k] && (cnt < pw[k]*PW_STEP). pw=0 gives no window.
  - While ch_en[k]=0, cnt is held at 0. It loads P-1 on the first enabled cycle.
- win = registered OR of all window_k (1 cycle after the counters).
- Edge detect: gen_r <= gen. rise = gen & ~gen_r, edge = gen ^ gen_r.
- gen_del = gen delayed one clk, to match ff latency.
- FSM transitions (ocd_s = synchronised ocd):
  - IDLE: on rise with win=1, set ff<=1 and go to RUN.
  - RUN: on rise with win=0, set ff<=0 and go to IDLE. The burst always ends on a full cycle.
  - IDLE or RUN with ocd_s=1: go to SKIP. ocd has priority over a simultaneous rise.
  - SKIP: on any edge, ff<=0. On each rise, skip_cnt decrements. ocd_act=1.
  - SKIP with skip_cnt==0: go to IDLE and reload SKIP_CNT_MAX. A still-high ocd_s re-enters SKIP next cycle.
- Outputs: out_p = ff & gen_del; out_n = ff & ~gen_del. They are never high together.
- Latency: gen edge to out change is 1 clk.
- If gen stops, ff holds its value. Outputs follow gen_del, so there is no forced drive.

Optional Feature:
- Macro INTERRUPTER_MC_MAX_ON_EN.
- When defined:
  - An on_cnt counts rises while in RUN.
  - At the MAX_ON_CYC-th rise, ff<=0 and the FSM enters HOLD.
  - HOLD returns to IDLE when win=0.
  - ocd takes HOLD to SKIP.
  - on_cnt clears on entry to RUN.
- When undefined: no on_cnt and no HOLD state; bursts last until the window closes.

Test Plan:
Benches run with PERIOD_BASE=100, PERIOD_STEP=10, PW_STEP=4, CH_NUM=2 and gen as a 20-clk-period square wave.
- Window timing:
  - Stimulus: write freq0=0, pw0=5, ch_en=1.
  - Required: win high 20 clk every 100 clk.
  - Required: out toggles only within bursts starting and ending on gen rises.
  - Required: out_p and out_n are never simultaneously high.
- Two channels OR:
  - Stimulus: freq0=0/pw0=2, freq1=5/pw1=3, ch_en=3.
  - Required: win is the OR of a 100-clk/8-clk pattern and a 150-clk/12-clk pattern.
- OCD skip:
  - Stimulus: pulse ocd mid-burst.
  - Required: ocd_act within 3 clk.
  - Required: out low from the next gen edge for exactly 3 gen rises, then IDLE and resume at the next rise inside the window.
- Freq write mid-period:
  - Stimulus: write freq0 from 0 to 2 at cnt=50.
  - Required: current period stays 100 clk; next period is 120 clk.
- Reset mid-burst:
  - Stimulus: drop rst_n while out_p=1.
  - Required: out_p, out_n, win, ocd_act are 0 immediately without a clk edge; registers read back as 0 (no window after release).
- Max-on (macro defined, MAX_ON_CYC=4, pw0=50):
  - Required: exactly 4 drive cycles per window, then no output until win falls.
